// File: rtl/ipg_pkg.sv
// Shared IPG definitions for the transmit and receive sides: sync headers,
// frame delimiters, idle block, marker layout and the FSM state type.
package ipg_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam logic [7:0] BT_START_78 = 8'h78;
  localparam logic [7:0] BT_START_33 = 8'h33;
  localparam logic [7:0] BT_START_66 = 8'h66;

  localparam logic [7:0] BT_TERM_87 = 8'h87;
  localparam logic [7:0] BT_TERM_99 = 8'h99;
  localparam logic [7:0] BT_TERM_AA = 8'hAA;
  localparam logic [7:0] BT_TERM_B4 = 8'hB4;
  localparam logic [7:0] BT_TERM_CC = 8'hCC;
  localparam logic [7:0] BT_TERM_D2 = 8'hD2;
  localparam logic [7:0] BT_TERM_E1 = 8'hE1;
  localparam logic [7:0] BT_TERM_FF = 8'hFF;

  localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;

  localparam logic [7:0] IPG_BTYPE_DEFAULT = 8'hE1;

  // Marker layout: byte0 block type, byte1 chunk count, byte2 sequence, rest zero
  localparam int MRK_BTYPE_LSB = 0;
  localparam int MRK_COUNT_LSB = 8;
  localparam int MRK_SEQ_LSB   = 16;
  localparam int MRK_PAD_LSB   = 24;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_FRAME = 2'd1,
    ST_MSG   = 2'd2
  } rx_state_t;

  function automatic logic is_start_type(input logic [7:0] bt);
    return (bt == BT_START_78) || (bt == BT_START_33) || (bt == BT_START_66);
  endfunction

  function automatic logic is_term_type(input logic [7:0] bt);
    return (bt == BT_TERM_87) || (bt == BT_TERM_99) || (bt == BT_TERM_AA) ||
           (bt == BT_TERM_B4) || (bt == BT_TERM_CC) || (bt == BT_TERM_D2) ||
           (bt == BT_TERM_E1) || (bt == BT_TERM_FF);
  endfunction

endpackage

// File: rtl/ipg_rx_fifo.sv
// First-word fall-through chunk FIFO with occupancy output and a registered
// overflow pulse for writes that arrive while full.
module ipg_rx_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO refuses the write even when a pop happens on the same edge
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign valid = (level_q != '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && valid;

  assign rd_data = valid ? mem[rd_ptr] : '0;
  assign level   = level_q;

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ipg_rx.sv
// IPG message extractor on the 10G BASE-R receive path. Pulls marker-framed
// chunks out of the inter-packet gap into a FIFO and replaces them with idles.
module ipg_rx
  import ipg_pkg::*;
#(
  parameter int             DATA_WIDTH = 64,
  parameter int             HDR_WIDTH  = 2,
  parameter int             MAX_CHUNKS = 16,
  parameter int             FIFO_DEPTH = 16,
  parameter logic [7:0]     IPG_BTYPE  = IPG_BTYPE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         encoded_rx_data,
  input  logic [HDR_WIDTH-1:0]          encoded_rx_hdr,
  input  logic                          rx_block_lock,
  output logic [DATA_WIDTH-1:0]         proced_encoded_rx_data,
  output logic [HDR_WIDTH-1:0]          proced_encoded_rx_hdr,
  output logic [DATA_WIDTH-1:0]         ipg_rx_chunk,
  output logic [7:0]                    ipg_rx_seq,
  output logic                          ipg_rx_last,
  output logic                          ipg_rx_valid,
  input  logic                          ipg_rx_ready,
  output logic                          ipg_rx_abort,
  output logic                          ipg_rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   ipg_rx_fifo_level
);

  localparam int ENTRY_W = DATA_WIDTH + 9;

  rx_state_t state_q, state_nxt;
  logic [7:0] rem_q, rem_nxt;
  logic [7:0] seq_q, seq_nxt;

  logic [7:0]            mrk_btype;
  logic [7:0]            mrk_count;
  logic [7:0]            mrk_seq;
  logic                  is_ctrl;
  logic                  is_data;
  logic                  is_start;
  logic                  is_term;
  logic                  is_marker;
  logic                  count_ok;

  logic [DATA_WIDTH-1:0] out_data;
  logic [HDR_WIDTH-1:0]  out_hdr;
  logic                  chunk_take;
  logic                  chunk_last;
  logic                  abort_nxt;
  logic                  gap_rules;

  logic [DATA_WIDTH-1:0] proced_data_p1;
  logic [HDR_WIDTH-1:0]  proced_hdr_p1;
  logic                  abort_p1;
  logic                  vld_p1;
  logic [ENTRY_W-1:0]    chunk_word_p1;
  logic [ENTRY_W-1:0]    fifo_head;

  assign mrk_btype = encoded_rx_data[MRK_BTYPE_LSB +: 8];
  assign mrk_count = encoded_rx_data[MRK_COUNT_LSB +: 8];
  assign mrk_seq   = encoded_rx_data[MRK_SEQ_LSB +: 8];

  assign is_ctrl   = (encoded_rx_hdr == SH_CTRL);
  assign is_data   = (encoded_rx_hdr == SH_DATA);
  assign is_start  = is_ctrl && is_start_type(mrk_btype);
  assign is_term   = is_ctrl && is_term_type(mrk_btype);
  assign is_marker = is_ctrl && (mrk_btype == IPG_BTYPE) &&
                     (encoded_rx_data[DATA_WIDTH-1:MRK_PAD_LSB] == '0);
  assign count_ok  = (mrk_count != 8'd0) && (int'(mrk_count) <= MAX_CHUNKS);

  // Next-state, substitution and chunk/abort decisions for the sampled block
  always_comb begin
    state_nxt  = state_q;
    rem_nxt    = rem_q;
    seq_nxt    = seq_q;
    out_hdr    = encoded_rx_hdr;
    out_data   = encoded_rx_data;
    chunk_take = 1'b0;
    chunk_last = 1'b0;
    abort_nxt  = 1'b0;
    gap_rules  = 1'b0;
    if (!rx_block_lock) begin
      state_nxt = ST_GAP;
      abort_nxt = (state_q == ST_MSG);
    end else begin
      case (state_q)
        ST_FRAME: begin
          if (is_term) state_nxt = ST_GAP;
        end
        ST_MSG: begin
          if (is_data) begin
            chunk_take = 1'b1;
            chunk_last = (rem_q == 8'd1);
            rem_nxt    = rem_q - 8'd1;
            out_hdr    = SH_CTRL;
            out_data   = IDLE_BLK;
            if (rem_q == 8'd1) state_nxt = ST_GAP;
          end else begin
            // Truncated message: the interrupting block is treated as a gap block
            abort_nxt = 1'b1;
            gap_rules = 1'b1;
          end
        end
        default: gap_rules = 1'b1;
      endcase
    end
    if (gap_rules) begin
      state_nxt = ST_GAP;
      if (is_start) begin
        state_nxt = ST_FRAME;
      end else if (is_marker) begin
        out_hdr  = SH_CTRL;
        out_data = IDLE_BLK;
        if (count_ok) begin
          state_nxt = ST_MSG;
          rem_nxt   = mrk_count;
          seq_nxt   = mrk_seq;
        end else begin
          abort_nxt = 1'b1;
        end
      end
    end
  end

  // FSM state with message count and sequence tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_GAP;
      rem_q   <= 8'd0;
      seq_q   <= 8'd0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      seq_q   <= seq_nxt;
    end
  end

  // Stage p1: decoder-facing block, abort pulse and chunk valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      proced_hdr_p1  <= SH_CTRL;
      proced_data_p1 <= IDLE_BLK;
      abort_p1       <= 1'b0;
      vld_p1         <= 1'b0;
    end else begin
      proced_hdr_p1  <= out_hdr;
      proced_data_p1 <= out_data;
      abort_p1       <= abort_nxt;
      vld_p1         <= chunk_take;
    end
  end

  // Stage p1: chunk payload travelling with vld_p1
  always_ff @(posedge clk) begin
    if (chunk_take) chunk_word_p1 <= {chunk_last, seq_q, encoded_rx_data};
  end

  ipg_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_p1),
    .wr_data  (chunk_word_p1),
    .rd_en    (ipg_rx_ready),
    .rd_data  (fifo_head),
    .valid    (ipg_rx_valid),
    .level    (ipg_rx_fifo_level),
    .overflow (ipg_rx_overflow)
  );

  assign proced_encoded_rx_hdr  = proced_hdr_p1;
  assign proced_encoded_rx_data = proced_data_p1;
  assign ipg_rx_abort           = abort_p1;
  assign ipg_rx_last            = fifo_head[ENTRY_W-1];
  assign ipg_rx_seq             = fifo_head[DATA_WIDTH +: 8];
  assign ipg_rx_chunk           = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ipg_rx.sv
// Bench for ipg_rx: directed scenarios followed by random traffic, every
// cycle compared against a queue-based behavioural model of the receiver.
module tb_ipg_rx;

  localparam int          MAXC   = 20;
  localparam int          FDEPTH = 16;
  localparam logic [63:0] IDLE   = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  HD     = 2'b01;
  localparam logic [1:0]  HC     = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] encoded_rx_data;
  logic [1:0]  encoded_rx_hdr;
  logic        rx_block_lock;
  logic [63:0] proced_encoded_rx_data;
  logic [1:0]  proced_encoded_rx_hdr;
  logic [63:0] ipg_rx_chunk;
  logic [7:0]  ipg_rx_seq;
  logic        ipg_rx_last;
  logic        ipg_rx_valid;
  logic        ipg_rx_ready;
  logic        ipg_rx_abort;
  logic        ipg_rx_overflow;
  logic [4:0]  ipg_rx_fifo_level;

  ipg_rx #(
    .DATA_WIDTH (64),
    .HDR_WIDTH  (2),
    .MAX_CHUNKS (MAXC),
    .FIFO_DEPTH (FDEPTH),
    .IPG_BTYPE  (8'hE1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .encoded_rx_data        (encoded_rx_data),
    .encoded_rx_hdr         (encoded_rx_hdr),
    .rx_block_lock          (rx_block_lock),
    .proced_encoded_rx_data (proced_encoded_rx_data),
    .proced_encoded_rx_hdr  (proced_encoded_rx_hdr),
    .ipg_rx_chunk           (ipg_rx_chunk),
    .ipg_rx_seq             (ipg_rx_seq),
    .ipg_rx_last            (ipg_rx_last),
    .ipg_rx_valid           (ipg_rx_valid),
    .ipg_rx_ready           (ipg_rx_ready),
    .ipg_rx_abort           (ipg_rx_abort),
    .ipg_rx_overflow        (ipg_rx_overflow),
    .ipg_rx_fifo_level      (ipg_rx_fifo_level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model state: 0 = between packets, 1 = inside a frame, 2 = receiving a message
  int           m_mode = 0;
  int           m_rem  = 0;
  logic [7:0]   m_seq  = 8'd0;
  logic [1:0]   m_ph   = HC;
  logic [63:0]  m_pd   = IDLE;
  logic         m_abort = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         pend_vld = 1'b0;
  logic [72:0]  pend_word = '0;
  logic [72:0]  exp_q[$];

  function automatic logic [63:0] marker(input int n, input logic [7:0] s);
    return {40'h0, s, 8'(n), 8'hE1};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one block, advance one edge, update the model, compare all outputs
  task automatic tick(input logic [1:0] h, input logic [63:0] d, input logic lk,
                      input logic rdy, input logic rs);
    logic [7:0]  bt, n, sq;
    logic        is_ctl, is_mrk, is_st, is_tm, full;
    logic [72:0] head;
    encoded_rx_hdr  = h;
    encoded_rx_data = d;
    rx_block_lock   = lk;
    ipg_rx_ready    = rdy;
    rst             = rs;
    @(posedge clk);
    bt = d[7:0];
    n  = d[15:8];
    sq = d[23:16];
    is_ctl = (h == HC);
    is_mrk = is_ctl && (bt == 8'hE1) && (d[63:24] == 40'h0);
    is_st  = is_ctl && (bt inside {8'h78, 8'h33, 8'h66});
    is_tm  = is_ctl && (bt inside {8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF});
    if (!rs) begin
      m_mode = 0; m_ph = HC; m_pd = IDLE; m_abort = 1'b0; m_ovf = 1'b0;
      pend_vld = 1'b0; exp_q.delete();
    end else begin
      full  = (exp_q.size() == FDEPTH);
      m_ovf = pend_vld && full;
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend_vld && !full) exp_q.push_back(pend_word);
      pend_vld = 1'b0;
      m_abort  = 1'b0;
      m_ph = h;
      m_pd = d;
      if (!lk) begin
        if (m_mode == 2) m_abort = 1'b1;
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (is_tm) m_mode = 0;
      end else if (m_mode == 2 && h == HD) begin
        pend_vld  = 1'b1;
        pend_word = {(m_rem == 1), m_seq, d};
        m_rem     = m_rem - 1;
        m_ph = HC; m_pd = IDLE;
        if (m_rem == 0) m_mode = 0;
      end else begin
        if (m_mode == 2) m_abort = 1'b1;
        m_mode = 0;
        if (is_st) m_mode = 1;
        else if (is_mrk) begin
          m_ph = HC; m_pd = IDLE;
          if (n >= 1 && int'(n) <= MAXC) begin
            m_mode = 2; m_rem = int'(n); m_seq = sq;
          end else m_abort = 1'b1;
        end
      end
    end
    #1;
    head = (exp_q.size() > 0) ? exp_q[0] : 73'h0;
    chk("proced_hdr",  73'(proced_encoded_rx_hdr),  73'(m_ph));
    chk("proced_data", 73'(proced_encoded_rx_data), 73'(m_pd));
    chk("abort",       73'(ipg_rx_abort),    73'(m_abort));
    chk("overflow",    73'(ipg_rx_overflow), 73'(m_ovf));
    chk("valid",       73'(ipg_rx_valid),    73'(exp_q.size() > 0));
    chk("level",       73'(ipg_rx_fifo_level), 73'(exp_q.size()));
    chk("chunk",       73'(ipg_rx_chunk), 73'(head[63:0]));
    chk("seq",         73'(ipg_rx_seq),   73'(head[71:64]));
    chk("last",        73'(ipg_rx_last),  73'(head[72]));
    @(negedge clk);
  endtask

  task automatic blk(input logic [1:0] h, input logic [63:0] d, input logic rdy);
    tick(h, d, 1'b1, rdy, 1'b1);
  endtask

  initial begin
    logic [63:0] a, b, c, dd;
    int          r, ovf_seen;
    encoded_rx_hdr = HC; encoded_rx_data = IDLE; rx_block_lock = 1'b1;
    ipg_rx_ready = 1'b0; rst = 1'b0;

    // Reset with junk on the inputs
    tick(HD, rnd64(), 1'b1, 1'b0, 1'b0);
    tick(HC, marker(3, 8'h11), 1'b1, 1'b1, 1'b0);
    chk("reset_level", 73'(ipg_rx_fifo_level), 73'd0);
    chk("reset_proced", 73'(proced_encoded_rx_data), 73'(IDLE));

    // Clean message N=3 seq=5, consumer stalled until all three are in
    a = rnd64(); b = rnd64(); c = rnd64();
    blk(HC, marker(3, 8'h05), 1'b0);
    blk(HD, a, 1'b0);
    blk(HD, b, 1'b0);
    blk(HD, c, 1'b0);
    blk(HC, IDLE, 1'b0);
    chk("clean_level", 73'(ipg_rx_fifo_level), 73'd3);
    chk("clean_head", 73'(ipg_rx_chunk), 73'(a));
    for (int i = 0; i < 4; i++) blk(HC, IDLE, 1'b1);

    // In-frame immunity, including a data block shaped like a marker
    blk(HC, {rnd64()>>8, 8'h78}, 1'b1);
    blk(HD, rnd64(), 1'b1);
    blk(HD, marker(2, 8'h09), 1'b1);
    blk(HC, {56'h0, 8'h87}, 1'b1);
    blk(HC, IDLE, 1'b1);
    chk("frame_level", 73'(ipg_rx_fifo_level), 73'd0);

    // Truncation by a start block, then close the frame
    blk(HC, marker(4, 8'h07), 1'b0);
    blk(HD, rnd64(), 1'b0);
    blk(HD, rnd64(), 1'b0);
    blk(HC, {56'h123456, 8'h33}, 1'b0);
    chk("trunc_abort", 73'(ipg_rx_abort), 73'd1);
    blk(HD, marker(1, 8'h01), 1'b0);
    chk("trunc_level", 73'(ipg_rx_fifo_level), 73'd2);
    blk(HC, {56'h0, 8'hFF}, 1'b0);
    for (int i = 0; i < 3; i++) blk(HC, IDLE, 1'b1);

    // Bad markers
    blk(HC, marker(0, 8'h01), 1'b1);
    chk("bad0_abort", 73'(ipg_rx_abort), 73'd1);
    blk(HC, marker(MAXC + 1, 8'h02), 1'b1);
    chk("badmax_abort", 73'(ipg_rx_abort), 73'd1);
    blk(HD, rnd64(), 1'b1);
    chk("bad_level", 73'(ipg_rx_fifo_level), 73'd0);

    // Overflow: 18 chunks into a 16-entry FIFO with the consumer stalled
    ovf_seen = 0;
    blk(HC, marker(18, 8'h03), 1'b0);
    for (int i = 0; i < 18; i++) begin
      blk(HD, {32'hC0DE_0000, 32'(i)}, 1'b0);
      if (ipg_rx_overflow) ovf_seen++;
    end
    blk(HC, IDLE, 1'b0);
    if (ipg_rx_overflow) ovf_seen++;
    chk("ovf_level", 73'(ipg_rx_fifo_level), 73'd16);
    chk("ovf_pulses", 73'(ovf_seen), 73'd2);
    for (int i = 0; i < 17; i++) blk(HC, IDLE, 1'b1);
    chk("ovf_drained", 73'(ipg_rx_fifo_level), 73'd0);

    // Full FIFO with a pop on the same edge as an incoming chunk
    blk(HC, marker(18, 8'h04), 1'b0);
    for (int i = 0; i < 17; i++) blk(HD, rnd64(), 1'b0);
    blk(HD, rnd64(), 1'b1);
    for (int i = 0; i < 18; i++) blk(HC, IDLE, 1'b1);

    // Lock loss mid-message
    blk(HC, marker(3, 8'h44), 1'b0);
    blk(HD, rnd64(), 1'b0);
    tick(HD, rnd64(), 1'b0, 1'b0, 1'b1);
    chk("lock_abort", 73'(ipg_rx_abort), 73'd1);
    blk(HD, rnd64(), 1'b0);
    for (int i = 0; i < 3; i++) blk(HC, IDLE, 1'b1);

    // Reset mid-message
    blk(HC, marker(3, 8'h66), 1'b0);
    blk(HD, rnd64(), 1'b0);
    blk(HD, rnd64(), 1'b0);
    tick(HD, rnd64(), 1'b1, 1'b0, 1'b0);
    chk("rst_valid", 73'(ipg_rx_valid), 73'd0);
    chk("rst_abort", 73'(ipg_rx_abort), 73'd0);
    blk(HD, rnd64(), 1'b1);
    blk(HC, IDLE, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin encoded_rx_hdr = HC; dd = IDLE; end
        1: begin encoded_rx_hdr = HC; dd = marker($urandom_range(0, MAXC + 2), 8'($urandom)); end
        5: begin
             encoded_rx_hdr = HC;
             case ($urandom_range(0, 2))
               0: dd = {rnd64() >> 8, 8'h78};
               1: dd = {rnd64() >> 8, 8'h33};
               default: dd = {rnd64() >> 8, 8'h66};
             endcase
           end
        6: begin
             encoded_rx_hdr = HC;
             case ($urandom_range(0, 3))
               0: dd = {56'h0, 8'h87};
               1: dd = {56'h0, 8'hE1};
               2: dd = {56'h0, 8'hCC};
               default: dd = {56'h0, 8'hFF};
             endcase
           end
        7: begin encoded_rx_hdr = HC; dd = rnd64(); end
        8: begin encoded_rx_hdr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00; dd = rnd64(); end
        default: begin encoded_rx_hdr = HD; dd = rnd64(); end
      endcase
      tick(encoded_rx_hdr, dd, ($urandom_range(0, 49) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
